// File: rtl/bbox_diff_scanner.sv
// bbox_diff_scanner: raster-scans background/live frames and reports the bounding box of changed pixels.
// Optional changed-pixel counter enabled by BBOX_DIFF_COUNT_EN.
module bbox_diff_scanner #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int CHANNELS = 3,
  parameter int PIX_BITS = 8,
  parameter int XW       = 11,
  parameter int ADDR_W   = $clog2(WIDTH*HEIGHT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PIX_BITS-1:0]          threshold,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [ADDR_W-1:0]            rd_addr,
  input  logic [CHANNELS*PIX_BITS-1:0] bg_data,
  input  logic [CHANNELS*PIX_BITS-1:0] fr_data,
  output logic                         found,
  output logic [XW-1:0]                x_min,
  output logic [XW-1:0]                x_max,
  output logic [XW-1:0]                y_min,
  output logic [XW-1:0]                y_max
`ifdef BBOX_DIFF_COUNT_EN
  , output logic [ADDR_W:0]            changed_count
`endif
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [PIX_BITS-1:0] thr_q, thr_d;
  logic [XW-1:0] x_q, x_d, y_q, y_d, xd_q, xd_d, yd_q, yd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic vld_q, vld_d, hit_q, hit_d, rfound_q, rfound_d;
  logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [XW-1:0] rxmin_q, rxmin_d, rxmax_q, rxmax_d, rymin_q, rymin_d, rymax_q, rymax_d;
  logic [PIX_BITS:0] diff, mag;
  logic go, last, xend, chg;
  assign go   = (state_q == IDLE) && start;
  assign last = addr_q == ADDR_W'(WIDTH*HEIGHT-1);
  assign xend = x_q == XW'(WIDTH-1);
  // Extra sign bit keeps the subtract exact so the magnitude never wraps.
  always_comb begin
    chg  = 1'b0;
    diff = '0;
    mag  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      diff = {1'b0, bg_data[c*PIX_BITS +: PIX_BITS]} - {1'b0, fr_data[c*PIX_BITS +: PIX_BITS]};
      mag  = diff[PIX_BITS] ? -diff : diff;
      chg  = chg | (mag > {1'b0, thr_q});
    end
  end
  always_comb begin
    state_d  = go ? SCAN : (state_q == SCAN && last) ? DRAIN :
               (state_q == DRAIN) ? DONE : (state_q == DONE) ? IDLE : state_q;
    thr_d    = go ? threshold : thr_q;
    addr_d   = go ? '0 : (state_q == SCAN) ? addr_q + ADDR_W'(1) : addr_q;
    x_d      = go ? '0 : (state_q == SCAN) ? (xend ? '0 : x_q + XW'(1)) : x_q;
    y_d      = go ? '0 : (state_q == SCAN && xend) ? y_q + XW'(1) : y_q;
    vld_d    = state_q == SCAN;
    xd_d     = x_q;
    yd_d     = y_q;
    hit_d    = go ? 1'b0 : hit_q | (vld_q && chg);
    xmin_d   = go ? XW'(WIDTH-1)  : (vld_q && chg && xd_q < xmin_q) ? xd_q : xmin_q;
    xmax_d   = go ? '0            : (vld_q && chg && xd_q > xmax_q) ? xd_q : xmax_q;
    ymin_d   = go ? XW'(HEIGHT-1) : (vld_q && chg && yd_q < ymin_q) ? yd_q : ymin_q;
    ymax_d   = go ? '0            : (vld_q && chg && yd_q > ymax_q) ? yd_q : ymax_q;
    // Results are captured from the next-state accumulators so the last pixel lands in time for DONE.
    rfound_d = (state_q == DRAIN) ? hit_d : rfound_q;
    rxmin_d  = (state_q == DRAIN) ? (hit_d ? xmin_d : '0) : rxmin_q;
    rxmax_d  = (state_q == DRAIN) ? (hit_d ? xmax_d : '0) : rxmax_q;
    rymin_d  = (state_q == DRAIN) ? (hit_d ? ymin_d : '0) : rymin_q;
    rymax_d  = (state_q == DRAIN) ? (hit_d ? ymax_d : '0) : rymax_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      thr_q    <= '0;
      addr_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      xd_q     <= '0;
      yd_q     <= '0;
      vld_q    <= 1'b0;
      hit_q    <= 1'b0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
      rfound_q <= 1'b0;
      rxmin_q  <= '0;
      rxmax_q  <= '0;
      rymin_q  <= '0;
      rymax_q  <= '0;
    end else begin
      state_q  <= state_d;
      thr_q    <= thr_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xd_q     <= xd_d;
      yd_q     <= yd_d;
      vld_q    <= vld_d;
      hit_q    <= hit_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      rfound_q <= rfound_d;
      rxmin_q  <= rxmin_d;
      rxmax_q  <= rxmax_d;
      rymin_q  <= rymin_d;
      rymax_q  <= rymax_d;
    end
  end
`ifdef BBOX_DIFF_COUNT_EN
  logic [ADDR_W:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  always_comb begin
    cnt_d  = go ? '0 : cnt_q + (ADDR_W+1)'(vld_q && chg);
    rcnt_d = (state_q == DRAIN) ? cnt_d : rcnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rcnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rcnt_q <= rcnt_d;
    end
  end
  assign changed_count = rcnt_q;
`endif
  assign busy    = (state_q == SCAN) || (state_q == DRAIN);
  assign done    = state_q == DONE;
  assign rd_en   = state_q == SCAN;
  assign rd_addr = addr_q;
  assign found   = rfound_q;
  assign x_min   = rxmin_q;
  assign x_max   = rxmax_q;
  assign y_min   = rymin_q;
  assign y_max   = rymax_q;
endmodule

// File: tb/tb_bbox_diff_scanner.sv
// tb_bbox_diff_scanner: directed checks on a 4x3 frame and a 1x1 frame with 1-cycle memory models.
module tb_bbox_diff_scanner;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, u_start = 1'b0;
  logic [7:0] threshold = 8'd0;
  logic busy, done, rd_en, found;
  logic [3:0] rd_addr, x_min, x_max, y_min, y_max;
  logic [23:0] bg_data = '0, fr_data = '0;
  logic [23:0] bg_mem [16];
  logic [23:0] fr_mem [16];
  logic u_busy, u_done, u_rd_en, u_found;
  logic [0:0] u_rd_addr;
  logic [1:0] u_x_min, u_x_max, u_y_min, u_y_max;
  logic [23:0] u_bg_data = '0, u_fr_data = '0;
  logic [23:0] u_bg = 24'h123456, u_fr = 24'h123457;
`ifdef BBOX_DIFF_COUNT_EN
  logic [4:0] changed_count;
  logic [1:0] u_changed_count;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bbox_diff_scanner #(.WIDTH(4), .HEIGHT(3), .CHANNELS(3), .PIX_BITS(8), .XW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .bg_data(bg_data), .fr_data(fr_data), .found(found),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max)
`ifdef BBOX_DIFF_COUNT_EN
    , .changed_count(changed_count)
`endif
  );

  bbox_diff_scanner #(.WIDTH(1), .HEIGHT(1), .CHANNELS(3), .PIX_BITS(8), .XW(2), .ADDR_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(u_start), .threshold(threshold),
    .busy(u_busy), .done(u_done), .rd_en(u_rd_en), .rd_addr(u_rd_addr),
    .bg_data(u_bg_data), .fr_data(u_fr_data), .found(u_found),
    .x_min(u_x_min), .x_max(u_x_max), .y_min(u_y_min), .y_max(u_y_max)
`ifdef BBOX_DIFF_COUNT_EN
    , .changed_count(u_changed_count)
`endif
  );

  always @(posedge clk) begin
    if (rd_en) begin
      bg_data <= bg_mem[rd_addr];
      fr_data <= fr_mem[rd_addr];
    end
    if (u_rd_en) begin
      u_bg_data <= u_bg;
      u_fr_data <= u_fr;
    end
  end

  task automatic set_frames();
    for (int i = 0; i < 16; i++) begin
      bg_mem[i] = {8'(i*3), 8'(i*5), 8'(i*7)};
      fr_mem[i] = bg_mem[i];
    end
  endtask

  task automatic run_scan(input logic [7:0] th, input int pulse_at,
                          output int dcyc, output int bcyc, output int aerr);
    int n;
    threshold = th;
    @(negedge clk);
    start = 1'b1;
    dcyc = -1;
    bcyc = 0;
    aerr = 0;
    n = 0;
    for (int c = 1; c <= 40 && dcyc < 0; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (c == 1) threshold = ~th;
      if (busy) bcyc++;
      if (rd_en) begin
        if (rd_addr !== 4'(n)) aerr++;
        n++;
      end
      if (done) dcyc = c;
    end
    if (n != 12) aerr++;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, rd_en, found} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {busy, done, rd_en, found}); end
    checks++;
    if (rd_addr !== 4'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", rd_addr); end
    checks++;
    if ({x_min, x_max, y_min, y_max} !== 16'h0) begin errors++; $display("FAIL reset_box got %h want 0000", {x_min, x_max, y_min, y_max}); end
`ifdef BBOX_DIFF_COUNT_EN
    checks++;
    if (changed_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", changed_count); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identical();
    int d, b, a;
    set_frames();
    run_scan(8'd0, -1, d, b, a);
    checks++;
    if (d != 14) begin errors++; $display("FAIL identical_done_cycle got %0d want 14", d); end
    checks++;
    if (b != 13) begin errors++; $display("FAIL identical_busy_cycles got %0d want 13", b); end
    checks++;
    if (a != 0) begin errors++; $display("FAIL identical_addr_seq got %0d errors want 0", a); end
    checks++;
    if (found !== 1'b0) begin errors++; $display("FAIL identical_found got %b want 0", found); end
    checks++;
    if ({x_min, x_max, y_min, y_max} !== 16'h0) begin errors++; $display("FAIL identical_box got %h want 0000", {x_min, x_max, y_min, y_max}); end
`ifdef BBOX_DIFF_COUNT_EN
    checks++;
    if (changed_count !== 5'd0) begin errors++; $display("FAIL identical_count got %0d want 0", changed_count); end
`endif
  endtask

  task automatic test_single();
    int d, b, a, nd;
    set_frames();
    fr_mem[6] = bg_mem[6] + 24'h000500;
    run_scan(8'd4, 5, d, b, a);
    checks++;
    if (d != 14) begin errors++; $display("FAIL single_done_cycle got %0d want 14", d); end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL single_found got %b want 1", found); end
    checks++;
    if ({x_min, x_max, y_min, y_max} !== 16'h2211) begin errors++; $display("FAIL single_box got %h want 2211", {x_min, x_max, y_min, y_max}); end
`ifdef BBOX_DIFF_COUNT_EN
    checks++;
    if (changed_count !== 5'd1) begin errors++; $display("FAIL single_count got %0d want 1", changed_count); end
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_at_done_ignored busy got %b want 0", busy); end
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL single_stray_activity got %0d cycles want 0", nd); end
    run_scan(8'd5, -1, d, b, a);
    checks++;
    if (found !== 1'b0) begin errors++; $display("FAIL single_th5_found got %b want 0", found); end
    checks++;
    if ({x_min, x_max, y_min, y_max} !== 16'h0) begin errors++; $display("FAIL single_th5_box got %h want 0000", {x_min, x_max, y_min, y_max}); end
  endtask

  task automatic test_corners();
    int d, b, a;
    set_frames();
    fr_mem[3] = bg_mem[3] & 24'hFFFF00;
    fr_mem[8] = {8'hFF, bg_mem[8][15:0]};
    fr_mem[5] = bg_mem[5] + 24'h000010;
    run_scan(8'h10, -1, d, b, a);
    checks++;
    if (d != 14) begin errors++; $display("FAIL corners_done_cycle got %0d want 14", d); end
    checks++;
    if (b != 13) begin errors++; $display("FAIL corners_busy_cycles got %0d want 13", b); end
    checks++;
    if (a != 0) begin errors++; $display("FAIL corners_addr_seq got %0d errors want 0", a); end
    checks++;
    if ({found, x_min, x_max, y_min, y_max} !== 17'h10302) begin errors++; $display("FAIL corners_box got %h want 10302", {found, x_min, x_max, y_min, y_max}); end
`ifdef BBOX_DIFF_COUNT_EN
    checks++;
    if (changed_count !== 5'd2) begin errors++; $display("FAIL corners_count got %0d want 2", changed_count); end
`endif
    repeat (5) @(negedge clk);
    checks++;
    if ({found, x_min, x_max, y_min, y_max} !== 17'h10302) begin errors++; $display("FAIL corners_hold got %h want 10302", {found, x_min, x_max, y_min, y_max}); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    set_frames();
    fr_mem[6] = bg_mem[6] + 24'h000500;
    threshold = 8'd4;
    d1 = -1;
    d2 = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 29; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = c;
        else d2 = c;
      end
      if (c == 14) begin
        fr_mem[11] = bg_mem[11] ^ 24'h000080;
        checks++;
        if ({found, x_min, x_max, y_min, y_max} !== 17'h12211) begin errors++; $display("FAIL b2b_first got %h want 12211", {found, x_min, x_max, y_min, y_max}); end
      end
      if (c == 28) begin
        checks++;
        if ({found, x_min, x_max, y_min, y_max} !== 17'h12211) begin errors++; $display("FAIL b2b_hold got %h want 12211", {found, x_min, x_max, y_min, y_max}); end
      end
      if (c == 29) begin
        checks++;
        if ({found, x_min, x_max, y_min, y_max} !== 17'h12312) begin errors++; $display("FAIL b2b_second got %h want 12312", {found, x_min, x_max, y_min, y_max}); end
`ifdef BBOX_DIFF_COUNT_EN
        checks++;
        if (changed_count !== 5'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", changed_count); end
`endif
      end
    end
    start = 1'b0;
    checks++;
    if (d1 != 14 || d2 != 29) begin errors++; $display("FAIL b2b_done_cycles got %0d,%0d want 14,29", d1, d2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int d, b, a, nd;
    threshold = 8'd4;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 6) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, rd_en, found} !== 4'b0) begin errors++; $display("FAIL midreset_flags got %b want 0000", {busy, done, rd_en, found}); end
    checks++;
    if ({x_min, x_max, y_min, y_max} !== 16'h0) begin errors++; $display("FAIL midreset_box got %h want 0000", {x_min, x_max, y_min, y_max}); end
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL midreset_done_pulses got %0d want 0", nd); end
    run_scan(8'd4, -1, d, b, a);
    checks++;
    if (d != 14 || a != 0) begin errors++; $display("FAIL midreset_rescan done_cycle %0d addr_err %0d want 14,0", d, a); end
    checks++;
    if ({found, x_min, x_max, y_min, y_max} !== 17'h12312) begin errors++; $display("FAIL midreset_rescan_box got %h want 12312", {found, x_min, x_max, y_min, y_max}); end
  endtask

  task automatic test_degenerate();
    int d, b, a;
    threshold = 8'd0;
    d = -1;
    b = 0;
    a = 0;
    @(negedge clk);
    u_start = 1'b1;
    for (int c = 1; c <= 10 && d < 0; c++) begin
      @(negedge clk);
      u_start = 1'b0;
      if (u_busy) b++;
      if (u_rd_en && u_rd_addr !== 1'b0) a++;
      if (u_done) d = c;
    end
    checks++;
    if (d != 3) begin errors++; $display("FAIL degen_done_cycle got %0d want 3", d); end
    checks++;
    if (b != 2 || a != 0) begin errors++; $display("FAIL degen_busy_addr busy %0d addr_err %0d want 2,0", b, a); end
    checks++;
    if ({u_found, u_x_min, u_x_max, u_y_min, u_y_max} !== 9'h100) begin errors++; $display("FAIL degen_box got %h want 100", {u_found, u_x_min, u_x_max, u_y_min, u_y_max}); end
`ifdef BBOX_DIFF_COUNT_EN
    checks++;
    if (u_changed_count !== 2'd1) begin errors++; $display("FAIL degen_count got %0d want 1", u_changed_count); end
`endif
  endtask

  initial begin
    set_frames();
    test_reset();
    test_identical();
    test_single();
    test_corners();
    test_back_to_back();
    test_reset_mid();
    test_degenerate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
